// File: rtl/bcd_encoder_seq.sv
// bcd_encoder_seq
//  Sequential binary-to-BCD converter using shift-add-3 (double dabble).
//  It converts a WIDTH-bit unsigned value into DIGITS packed BCD digits,
//  processing one input bit per clock. A start/busy/done handshake is used.
//  Results that need more than DIGITS digits are truncated to the correct
//  low digits, and overflow is raised.
//
// Ports
//  clk        in   1         system clock; all state changes on the rising edge
//  reset_n    in   1         asynchronous assert, active-low reset
//  start      in   1         request a conversion; sampled only while busy==0
//  binary_in  in   WIDTH     unsigned value, captured on the accepting edge
//  busy       out  1         conversion in progress
//  done       out  1         one-cycle pulse; bcd/overflow were just updated
//  bcd        out  4*DIGITS  packed BCD, units digit in [3:0]
//  overflow   out  1         value exceeded 10^DIGITS-1 (qualifies bcd)
module bcd_encoder_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q,   state_d;
  logic [CW-1:0]         cnt_q,     cnt_d;
  logic [WIDTH-1:0]      shift_q,   shift_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic                  ovf_scr_q, ovf_scr_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic [4*DIGITS-1:0]   bcd_q,     bcd_d;
  logic                  overflow_q, overflow_d;

  // Scratch digits after the add-3 correction. Each digit is handled in parallel.
  logic [4*DIGITS-1:0]   adj_scratch;
  // Scratch value after this cycle's shift, and the bit shifted out of the top digit.
  logic [4*DIGITS-1:0]   next_scratch;
  logic                  carry_out;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
    assign adj_scratch[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                    ? scratch_q[4*gi +: 4] + 4'd3
                                    : scratch_q[4*gi +: 4];
  end

  assign next_scratch = {adj_scratch[4*DIGITS-2:0], shift_q[WIDTH-1]};
  assign carry_out    = adj_scratch[4*DIGITS-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_scr_d  = ovf_scr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = binary_in;
          scratch_d = '0;
          ovf_scr_d = 1'b0;
          cnt_d     = CW'(WIDTH);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = shift_q << 1;
        scratch_d = next_scratch;
        // A bit that leaves the top digit means the value needs more digits.
        ovf_scr_d = ovf_scr_q | carry_out;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Publish the result directly from this edge's shift and carry.
          bcd_d      = next_scratch;
          overflow_d = ovf_scr_q | carry_out;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_scr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_scr_q  <= ovf_scr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule
